// File: rtl/regfile_debug_dumper.sv
// Register file debug dumper: freezes the pipeline, walks every GPR
// through the debug read port and streams the values as bytes.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   dump_req        : start a dump (ignored while busy)
//   reg_debug_data  : register file debug read data
//   tx_ready        : byte sink ready
//   stop_debug      : pipeline freeze
//   debug_on        : register file write inhibit
//   debug_read_reg  : register file debug read address
//   tx_data/tx_valid: byte stream to the UART transmitter
//   busy            : dump in progress
//   done            : one-cycle pulse when the last byte is accepted
module regfile_debug_dumper #(
  parameter int          NUM_REGS      = 32,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_req,
  input  logic [31:0] reg_debug_data,
  input  logic        tx_ready,
  output logic        stop_debug,
  output logic        debug_on,
  output logic [4:0]  debug_read_reg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [4:0]    LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [SW-1:0] SETTLE   = SW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    ADDR,
    SEND
  } state_e;

  state_e        state_q, state_d;
  logic          freeze_q, freeze_d;
  logic [4:0]    idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [1:0]    byte_q, byte_d;
  // Bytes still to send after the one on tx_data, MSB first.
  logic [23:0]   rest_q, rest_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          done_q, done_d;

  always_comb begin
    state_d    = state_q;
    freeze_d   = freeze_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    byte_d     = byte_q;
    rest_d     = rest_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d    = HDR;
          freeze_d   = 1'b1;
          tx_data_d  = HEADER_BYTE;
          tx_valid_d = 1'b1;
          idx_d      = '0;
        end
      end
      HDR: begin
        if (tx_ready) begin
          state_d    = ADDR;
          tx_valid_d = 1'b0;
          settle_d   = '0;
        end
      end
      ADDR: begin
        settle_d = settle_q + 1'b1;
        if (settle_d == SETTLE) begin
          state_d    = SEND;
          rest_d     = reg_debug_data[23:0];
          tx_data_d  = reg_debug_data[31:24];
          tx_valid_d = 1'b1;
          byte_d     = '0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (byte_q == 2'd3) begin
            tx_valid_d = 1'b0;
            if (idx_q < LAST_IDX) begin
              idx_d    = idx_q + 1'b1;
              settle_d = '0;
              state_d  = ADDR;
            end else begin
              state_d   = IDLE;
              done_d    = 1'b1;
              freeze_d  = 1'b0;
              tx_data_d = '0;
              idx_d     = '0;
            end
          end else begin
            tx_data_d = rest_q[23:16];
            rest_d    = {rest_q[15:0], 8'h00};
            byte_d    = byte_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      freeze_q   <= 1'b0;
      idx_q      <= '0;
      settle_q   <= '0;
      byte_q     <= '0;
      rest_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      freeze_q   <= freeze_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      byte_q     <= byte_d;
      rest_q     <= rest_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  // One flop drives all three so they can never disagree.
  assign stop_debug     = freeze_q;
  assign debug_on       = freeze_q;
  assign busy           = freeze_q;
  assign debug_read_reg = idx_q;
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign done           = done_q;

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Bench for regfile_debug_dumper: random register contents and
// backpressure checked against a byte-stream model.
module tb_regfile_debug_dumper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req1 = 1'b0, req2 = 1'b0;
  logic tx_ready = 1'b1;
  logic [31:0] data1 = '0, data2 = '0;
  logic [31:0] regs [32];

  logic       stop1, don1, txv1, busy1, done1;
  logic [4:0] rd1;
  logic [7:0] txd1;
  logic       stop2, don2, txv2, busy2, done2;
  logic [4:0] rd2;
  logic [7:0] txd2;

  logic       sel = 1'b0;
  logic       m_stop, m_dbg, m_valid, m_busy, m_done;
  logic [4:0] m_rd;
  logic [7:0] m_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_debug_dumper u_dut (
    .clk(clk), .rst(rst), .dump_req(req1),
    .reg_debug_data(data1), .tx_ready(tx_ready),
    .stop_debug(stop1), .debug_on(don1),
    .debug_read_reg(rd1), .tx_data(txd1),
    .tx_valid(txv1), .busy(busy1), .done(done1)
  );

  regfile_debug_dumper #(
    .NUM_REGS(4), .SETTLE_CYCLES(3), .HEADER_BYTE(8'hA5)
  ) u_dut2 (
    .clk(clk), .rst(rst), .dump_req(req2),
    .reg_debug_data(data2), .tx_ready(tx_ready),
    .stop_debug(stop2), .debug_on(don2),
    .debug_read_reg(rd2), .tx_data(txd2),
    .tx_valid(txv2), .busy(busy2), .done(done2)
  );

  // Register file debug port, read on the falling edge.
  always @(negedge clk) begin
    data1 <= regs[rd1];
    data2 <= regs[rd2];
  end

  always_comb begin
    if (sel) begin
      m_stop = stop2; m_dbg = don2; m_valid = txv2;
      m_busy = busy2; m_done = done2; m_rd = rd2; m_data = txd2;
    end else begin
      m_stop = stop1; m_dbg = don1; m_valid = txv1;
      m_busy = busy1; m_done = done1; m_rd = rd1; m_data = txd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic v);
    if (sel) req2 = v;
    else req1 = v;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {stop1, don1, rd1, txd1, txv1, busy1, done1}, 0);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  task automatic run_dump(input bit bp, input bit poke, input bit hold,
                          input int n, input int s);
    byte unsigned expq[$];
    byte unsigned gotq[$];
    int done_k;
    logic pv, pr;
    logic [7:0] pd;
    logic [31:0] g;
    expq.push_back(8'hA5);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++)
        expq.push_back(regs[i][31-8*b -: 8]);
    @(negedge clk);
    drive_req(1'b1);
    tx_ready = 1'b1;
    pv = 1'b0; pr = 1'b0; pd = '0; done_k = -1;
    for (int k = 0; k < 6000 && done_k < 0; k++) begin
      @(negedge clk);
      if (!hold) drive_req(1'b0);
      if (poke && (k == 3 || k == 20 || k == 41)) drive_req(1'b1);
      if (pv && !pr) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, pd);
      end
      chk("freeze", {m_stop, m_dbg, m_busy}, m_done ? 0 : 3'b111);
      if (m_done) done_k = k;
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && tx_ready) gotq.push_back(m_data);
      pv = m_valid; pr = tx_ready; pd = m_data;
    end
    chk("done_seen", done_k >= 0, 1);
    if (!bp) chk("done_latency", done_k, 1 + n * (s + 4));
    chk("byte_count", gotq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      g = (i < gotq.size()) ? 32'(gotq[i]) : 32'hFFFF_FFFF;
      chk("byte", g, 32'(expq[i]));
    end
    if (hold) begin
      @(negedge clk);
      chk("restart_valid", m_valid, 1);
      chk("restart_hdr", m_data, 8'hA5);
      chk("restart_busy", m_busy, 1);
      drive_req(1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      repeat (3) begin
        @(negedge clk);
        chk("extra_done", m_done, 0);
        chk("idle_busy", m_busy, 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    req1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_zero("reset_outputs");
    rst = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    all_zero("idle_after_reset");

    run_dump(0, 0, 0, 32, 1);
    rand_regs();
    run_dump(1, 0, 0, 32, 1);

    rand_regs();
    @(negedge clk);
    req1 = 1'b1;
    for (int k = 0; k <= 38; k++) begin
      @(negedge clk);
      req1 = 1'b0;
    end
    chk("mid_reg", rd1, 7);
    chk("mid_valid", txv1, 1);
    rst = 1'b1;
    @(negedge clk);
    all_zero("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    all_zero("mid_reset_idle");
    run_dump(0, 0, 0, 32, 1);

    rand_regs();
    run_dump(0, 1, 0, 32, 1);

    sel = 1'b1;
    rand_regs();
    run_dump(0, 0, 0, 4, 3);
    rand_regs();
    run_dump(1, 0, 0, 4, 3);

    sel = 1'b0;
    rand_regs();
    run_dump(0, 0, 1, 32, 1);
    @(negedge clk);
    all_zero("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
